// File: rtl/vp_bitmap_to_pixels_pipe.sv
// Two-stage bitmap-to-pixel expander with valid/ready flow control: decode, then expand.
// Optional blink support is built when VP_BITMAP_BLINK_EN is defined.
module vp_bitmap_to_pixels_pipe #(
  parameter int unsigned BITMAP_WIDTH = 16,
  parameter int unsigned COLOUR_BITS  = 4
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [COLOUR_BITS-1:0]              foreground,
  input  logic [COLOUR_BITS-1:0]              background,
  input  logic [BITMAP_WIDTH-1:0]             bitmap,
  input  logic [1:0]                          mode,
`ifdef VP_BITMAP_BLINK_EN
  input  logic                                blink,
  input  logic                                blink_tick,
`endif
  input  logic                                enabled,
  output logic                                ready_in,
  output logic [BITMAP_WIDTH*COLOUR_BITS-1:0] pixels,
  output logic                                enable,
  input  logic                                ready_out
);

  localparam int unsigned HALF = BITMAP_WIDTH / 2;

  typedef enum logic [1:0] {
    MODE_NORMAL  = 2'd0,
    MODE_INVERSE = 2'd1,
    MODE_DBL_L   = 2'd2,
    MODE_DBL_R   = 2'd3
  } mode_e;

  logic                                r_s1_v;
  logic [BITMAP_WIDTH-1:0]             r_s1_eb;
  logic [COLOUR_BITS-1:0]              r_s1_fg;
  logic [COLOUR_BITS-1:0]              r_s1_bg;
  logic                                r_s1_blank;
  logic                                r_s2_v;
  logic [BITMAP_WIDTH*COLOUR_BITS-1:0] r_pixels;

  logic                                w_s2_load;
  logic                                w_s1_load;
  logic                                w_in_xfer;
  logic [BITMAP_WIDTH-1:0]             w_eb;
  logic [COLOUR_BITS-1:0]              w_fg;
  logic [COLOUR_BITS-1:0]              w_bg;
  logic                                w_blank;
  logic [BITMAP_WIDTH*COLOUR_BITS-1:0] w_px;

  assign w_s2_load = !r_s2_v || ready_out;
  assign w_s1_load = !r_s1_v || w_s2_load;
  assign w_in_xfer = enabled && w_s1_load;

  assign ready_in = w_s1_load;
  assign enable   = r_s2_v;
  assign pixels   = r_pixels;

  always_comb begin
    w_eb = bitmap;
    w_fg = foreground;
    w_bg = background;
    case (mode_e'(mode))
      MODE_INVERSE: begin
        w_fg = background;
        w_bg = foreground;
      end
      MODE_DBL_L: begin
        for (int unsigned k = 0; k < HALF; k++) begin
          w_eb[2*k]   = bitmap[HALF+k];
          w_eb[2*k+1] = bitmap[HALF+k];
        end
      end
      MODE_DBL_R: begin
        for (int unsigned k = 0; k < HALF; k++) begin
          w_eb[2*k]   = bitmap[k];
          w_eb[2*k+1] = bitmap[k];
        end
      end
      default: ;
    endcase
  end

`ifdef VP_BITMAP_BLINK_EN
  logic r_phase;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_phase <= 1'b0;
    end else if (blink_tick) begin
      r_phase <= ~r_phase;
    end
  end

  // The row captures the phase value present before any same-cycle toggle.
  assign w_blank = blink && r_phase;
`else
  assign w_blank = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_s1_v     <= 1'b0;
      r_s1_eb    <= '0;
      r_s1_fg    <= '0;
      r_s1_bg    <= '0;
      r_s1_blank <= 1'b0;
    end else if (w_s1_load) begin
      r_s1_v <= w_in_xfer;
      if (w_in_xfer) begin
        r_s1_eb    <= w_eb;
        r_s1_fg    <= w_fg;
        r_s1_bg    <= w_bg;
        r_s1_blank <= w_blank;
      end
    end
  end

  always_comb begin
    w_px = '0;
    for (int unsigned i = 0; i < BITMAP_WIDTH; i++) begin
      w_px[i*COLOUR_BITS +: COLOUR_BITS] = (r_s1_eb[i] && !r_s1_blank) ? r_s1_fg : r_s1_bg;
    end
  end

  // Data registers only move with a valid row so pixels holds while enable is low.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_s2_v   <= 1'b0;
      r_pixels <= '0;
    end else if (w_s2_load) begin
      r_s2_v <= r_s1_v;
      if (r_s1_v) begin
        r_pixels <= w_px;
      end
    end
  end

endmodule

// File: doc/vp_bitmap_to_pixels_pipe.md
Name: vp_bitmap_to_pixels_pipe

Overview:
- Parametrised, pipelined successor of the bitmap-to-pixels expander in the video pipeline.
- Converts a BITMAP_WIDTH-bit glyph/graphics row plus foreground and background colour indices into a packed row of colour-index pixels.
- Adds inverse and double-width render modes.
- Uses a valid/ready handshake with full backpressure, so it can sit between the character fetch stage and the pixel serialiser.

Parameters:
- BITMAP_WIDTH, 16: pixels per row. Must be even and ≥2.
- COLOUR_BITS, 4: bits per colour index.

Ports:
- clk  input  1  pipeline clock
- reset  input  1  asynchronous, active-low reset
- foreground  input  COLOUR_BITS  colour for set bitmap bits
- background  input  COLOUR_BITS  colour for clear bitmap bits
- bitmap  input  BITMAP_WIDTH  row bits; MSB is the leftmost pixel
- mode  input  2  render mode: 0 normal, 1 inverse, 2 double-width left half, 3 double-width right half
- enabled  input  1  input valid
- ready_in  output  1  block can accept input this cycle
- pixels  output  BITMAP_WIDTH*COLOUR_BITS  packed pixels; pixel i (bitmap bit i) occupies pixels[i*COLOUR_BITS +: COLOUR_BITS]
- enable  output  1  output valid
- ready_out  input  1  downstream accepts output

Behaviour:
- Reset (reset low, asynchronous):
  - Both stage valid flags clear; enable=0; pixels=0; internal registers=0.
  - ready_in becomes 1 as soon as both stages are empty (combinational).
  - Reset mid-operation discards any in-flight rows; no partial output after release.
- Transfer rules:
  - Input transfer when enabled && ready_in at a rising clk edge.
  - Output transfer when enable && ready_out.
- Stage 1 (decode), registers:
  - Expanded bitmap eb, effective colours efg/ebg, valid s1_v.
  - Mode 0: eb=bitmap, efg=foreground, ebg=background.
  - Mode 1: eb=bitmap, efg=background, ebg=foreground.
  - Mode 2: eb bits 2k+1 and 2k both = bitmap[BITMAP_WIDTH/2+k], for k=0..BITMAP_WIDTH/2-1. Colours as mode 0.
  - Mode 3: as mode 2, but sources bitmap[k].
- Stage 2 (expand), registers:
  - pixels slice i = eb[i] ? efg : ebg.
  - enable = s2_v.
- Flow control:
  - s2_load = !s2_v || ready_out.
  - s1_load = !s1_v || s2_load.
  - ready_in = s1_load (combinational from ready_out).
  - On s2_load, stage 2 takes stage 1's contents and s2_v <= s1_v.
  - On s1_load, stage 1 takes the input and s1_v <= (enabled && ready_in).
- Latency and throughput:
  - 2 cycles from input transfer to enable high when ready_out is held high.
  - One row per cycle sustained.
- Backpressure:
  - ready_out low with both stages full: ready_in=0, and pixels/enable hold stable until accepted.
  - No row is dropped or duplicated.
- Simultaneous events: input and output transfers in the same cycle with both stages full shift the pipeline by one stage; full throughput is maintained.
- pixels is held while enable=0; consumers must ignore it.

Optional Feature:
- Macro: VP_BITMAP_BLINK_EN.
- When defined:
  - Adds input blink (1 bit, travels with the row) and input blink_tick (1-bit pulse).
  - Internal phase flip-flop, reset to 0, toggles on each blink_tick.
  - Stage 1 latches blink && phase. When that latched value is set, stage 2 outputs ebg for every pixel.
  - blink_tick coinciding with a transfer: the row samples phase before the toggle.
- When undefined: ports and logic are absent; behaviour is exactly as above.

Test Plan:
- Normal mode: bitmap=16'b1010_0101_0000_1111, fg=15, bg=0, mode=0, ready_out=1 -> 2 cycles later enable=1, pixels=64'hF0F0_0F0F_0000_FFFF.
- Inverse: same row, mode=1 -> pixels=64'h0F0F_F0F0_FFFF_0000.
- Double-width: same row, mode=2 -> pixels=64'hFF00_FF00_00FF_00FF; mode=3 -> pixels=64'h0000_0000_FFFF_FFFF.
- Backpressure:
  - Stream 4 rows with enabled=1 and ready_out=0 -> ready_in drops after 2 accepted; enable and pixels hold row 1.
  - Raise ready_out -> rows 1..4 delivered in order, one per cycle.
- Reset mid-stream: pull reset low with 2 rows in flight -> enable=0 and pixels=0 immediately; after release, no stale row appears.
- VP_BITMAP_BLINK_EN: blink=1, fg=15, bg=2, all-ones bitmap:
  - phase=0 -> 64'hFFFF_FFFF_FFFF_FFFF.
  - After one blink_tick -> 64'h2222_2222_2222_2222.
